// File: rtl/sc_lanesched_if.sv
// Handshake and configuration bundle for the lane scheduler.
// The slave modport is the scheduler; the master modport is the game logic and shift datapath.
interface sc_lanesched_if;
    logic       SC_LANESCHED_run_In;
    logic       SC_LANESCHED_cfgWrite_In;
    logic [1:0] SC_LANESCHED_cfgLane_In;
    logic [7:0] SC_LANESCHED_cfgPeriod_In;
    logic       SC_LANESCHED_shiftReady_In;
    logic       SC_LANESCHED_shiftValid_Out;
    logic [1:0] SC_LANESCHED_shiftLane_Out;
    logic [1:0] SC_LANESCHED_shiftselection_Out;
    logic [3:0] SC_LANESCHED_overrun_Out;
    logic       SC_LANESCHED_busy_Out;

    modport slave (
        input  SC_LANESCHED_run_In, SC_LANESCHED_cfgWrite_In, SC_LANESCHED_cfgLane_In,
               SC_LANESCHED_cfgPeriod_In, SC_LANESCHED_shiftReady_In,
        output SC_LANESCHED_shiftValid_Out, SC_LANESCHED_shiftLane_Out,
               SC_LANESCHED_shiftselection_Out, SC_LANESCHED_overrun_Out, SC_LANESCHED_busy_Out
    );

    modport master (
        output SC_LANESCHED_run_In, SC_LANESCHED_cfgWrite_In, SC_LANESCHED_cfgLane_In,
               SC_LANESCHED_cfgPeriod_In, SC_LANESCHED_shiftReady_In,
        input  SC_LANESCHED_shiftValid_Out, SC_LANESCHED_shiftLane_Out,
               SC_LANESCHED_shiftselection_Out, SC_LANESCHED_overrun_Out, SC_LANESCHED_busy_Out
    );
endinterface

// File: rtl/sc_lanesched.sv
// Round-robin scheduler issuing periodic shift commands for four background lanes.
// Define SC_LANESCHED_OVERRUN_EN to build the sticky per-lane overrun flags.
//
// state    | meaning
// ST_IDLE  | game stopped, nothing issued
// ST_ARB   | pick the next pending lane from the round-robin pointer
// ST_ISSUE | command presented, waiting for shift datapath ready
module sc_lanesched #(
    parameter int PRESCALE  = 50000,
    parameter int NUM_LANES = 4
) (
    input  logic            SC_LANESCHED_CLOCK_50,
    input  logic            SC_LANESCHED_RESET_InHigh,
    sc_lanesched_if.slave   bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    logic [1:0]           state;
    logic [PW-1:0]        pre;
    logic                 tick;
    logic [7:0]           period [NUM_LANES];
    logic [7:0]           cnt    [NUM_LANES];
    logic [NUM_LANES-1:0] pending, pending_next;
    logic [NUM_LANES-1:0] wr_hit, expire, accept_hit;
    logic [1:0]           ptr, lane, pick, cand;
    logic                 accept;

    assign tick   = bus.SC_LANESCHED_run_In && (pre == PW'(PRESCALE - 1));
    assign accept = (state == ST_ISSUE) && bus.SC_LANESCHED_shiftReady_In;

    // A configuration write to a lane takes precedence over that lane's expiry on the same edge.
    always_comb begin
        wr_hit       = '0;
        expire       = '0;
        accept_hit   = '0;
        pending_next = pending;
        for (int l = 0; l < NUM_LANES; l++) begin
            wr_hit[l]     = bus.SC_LANESCHED_cfgWrite_In && (bus.SC_LANESCHED_cfgLane_In == 2'(l));
            expire[l]     = tick && (period[l] != 8'd0) && (cnt[l] <= 8'd1) && !wr_hit[l];
            accept_hit[l] = accept && (lane == 2'(l));
            if (wr_hit[l] && (bus.SC_LANESCHED_cfgPeriod_In == 8'd0))
                pending_next[l] = 1'b0;
            else if (expire[l])
                pending_next[l] = 1'b1;
            else if (accept_hit[l])
                pending_next[l] = 1'b0;
        end
    end

    // Scan downward so the smallest offset from the pointer wins.
    always_comb begin
        pick = ptr;
        cand = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (pending[cand])
                pick = cand;
        end
    end

    always_ff @(posedge SC_LANESCHED_CLOCK_50) begin
        if (SC_LANESCHED_RESET_InHigh) begin
            state   <= ST_IDLE;
            pre     <= '0;
            ptr     <= '0;
            lane    <= '0;
            pending <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                period[l] <= '0;
                cnt[l]    <= '0;
            end
        end else begin
            if (bus.SC_LANESCHED_run_In)
                pre <= tick ? '0 : pre + PW'(1);
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wr_hit[l]) begin
                    period[l] <= bus.SC_LANESCHED_cfgPeriod_In;
                    cnt[l]    <= bus.SC_LANESCHED_cfgPeriod_In;
                end else if (tick && (period[l] != 8'd0)) begin
                    cnt[l] <= (cnt[l] <= 8'd1) ? period[l] : cnt[l] - 8'd1;
                end
            end
            pending <= pending_next;
            case (state)
                ST_IDLE: begin
                    if (bus.SC_LANESCHED_run_In)
                        state <= ST_ARB;
                end
                ST_ARB: begin
                    if (!bus.SC_LANESCHED_run_In) begin
                        state <= ST_IDLE;
                    end else if (|pending) begin
                        lane  <= pick;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.SC_LANESCHED_shiftReady_In) begin
                        ptr   <= lane + 2'd1;
                        state <= bus.SC_LANESCHED_run_In ? ST_ARB : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SC_LANESCHED_OVERRUN_EN
    logic [NUM_LANES-1:0] ovr;

    always_ff @(posedge SC_LANESCHED_CLOCK_50) begin
        if (SC_LANESCHED_RESET_InHigh) begin
            ovr <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wr_hit[l])
                    ovr[l] <= 1'b0;
                else if (expire[l] && pending[l] && !accept_hit[l])
                    ovr[l] <= 1'b1;
            end
        end
    end

    assign bus.SC_LANESCHED_overrun_Out = ovr;
`else
    assign bus.SC_LANESCHED_overrun_Out = 4'b0000;
`endif

    assign bus.SC_LANESCHED_shiftValid_Out     = (state == ST_ISSUE);
    assign bus.SC_LANESCHED_shiftLane_Out      = lane;
    assign bus.SC_LANESCHED_shiftselection_Out = (state != ST_ISSUE) ? 2'b11 :
                                                 (lane[0] ? 2'b01 : 2'b10);
    assign bus.SC_LANESCHED_busy_Out           = (state != ST_IDLE);
endmodule

// File: tb/tb_sc_lanesched.sv
// Bench for sc_lanesched: directed scenarios plus random traffic against a behavioural model.
// Overrun expectations follow SC_LANESCHED_OVERRUN_EN.
module tb_sc_lanesched;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    sc_lanesched_if bus();

    sc_lanesched #(.PRESCALE(P), .NUM_LANES(4)) dut (
        .SC_LANESCHED_CLOCK_50    (clk),
        .SC_LANESCHED_RESET_InHigh(rst),
        .bus                      (bus)
    );

    always #5 clk = ~clk;

    // Reference model: lane timers as plain integers, scheduler as a three-phase activity.
    int m_period [4];
    int m_cnt    [4];
    bit m_pend   [4];
    bit m_ovr    [4];
    int m_pre, m_phase, m_lane, m_ptr;   // phase 0 stopped, 1 choosing, 2 offering

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        bit old_pend [4];
        bit acc, tick, wr, exp_now;
        if (rst) begin
            for (int l = 0; l < 4; l++) begin
                m_period[l] = 0; m_cnt[l] = 0; m_pend[l] = 0; m_ovr[l] = 0;
            end
            m_pre = 0; m_phase = 0; m_lane = 0; m_ptr = 0;
            return;
        end
        old_pend = m_pend;
        acc  = (m_phase == 2) && bus.SC_LANESCHED_shiftReady_In;
        tick = bus.SC_LANESCHED_run_In && (m_pre == P - 1);
        if (bus.SC_LANESCHED_run_In) m_pre = (m_pre + 1) % P;
        for (int l = 0; l < 4; l++) begin
            wr = bus.SC_LANESCHED_cfgWrite_In && (int'(bus.SC_LANESCHED_cfgLane_In) == l);
            if (wr) begin
                m_period[l] = int'(bus.SC_LANESCHED_cfgPeriod_In);
                m_cnt[l]    = m_period[l];
                m_ovr[l]    = 0;
                if (m_period[l] == 0) m_pend[l] = 0;
                else if (acc && m_lane == l) m_pend[l] = 0;
            end else begin
                exp_now = 0;
                if (tick && m_period[l] != 0) begin
                    if (m_cnt[l] <= 1) begin exp_now = 1; m_cnt[l] = m_period[l]; end
                    else m_cnt[l] = m_cnt[l] - 1;
                end
                if (exp_now) begin
                    if (old_pend[l] && !(acc && m_lane == l)) m_ovr[l] = 1;
                    m_pend[l] = 1;
                end else if (acc && m_lane == l) begin
                    m_pend[l] = 0;
                end
            end
        end
        if (m_phase == 0) begin
            if (bus.SC_LANESCHED_run_In) m_phase = 1;
        end else if (m_phase == 1) begin
            if (!bus.SC_LANESCHED_run_In) m_phase = 0;
            else begin
                for (int k = 3; k >= 0; k--)
                    if (old_pend[(m_ptr + k) % 4]) begin m_lane = (m_ptr + k) % 4; m_phase = 2; end
            end
        end else if (acc) begin
            m_ptr   = (m_lane + 1) % 4;
            m_phase = bus.SC_LANESCHED_run_In ? 1 : 0;
        end
    endtask

    function automatic logic [3:0] exp_ovr();
        logic [3:0] v = '0;
`ifdef SC_LANESCHED_OVERRUN_EN
        for (int l = 0; l < 4; l++) v[l] = m_ovr[l];
`endif
        return v;
    endfunction

    task automatic compare_all();
        bit ev = (m_phase == 2);
        chk("valid", 32'(bus.SC_LANESCHED_shiftValid_Out), 32'(ev));
        if (ev) chk("lane", 32'(bus.SC_LANESCHED_shiftLane_Out), 32'(m_lane));
        chk("sel", 32'(bus.SC_LANESCHED_shiftselection_Out),
            ev ? ((m_lane % 2 == 0) ? 32'd2 : 32'd1) : 32'd3);
        chk("busy", 32'(bus.SC_LANESCHED_busy_Out), 32'(m_phase != 0));
        chk("overrun", 32'(bus.SC_LANESCHED_overrun_Out), 32'(exp_ovr()));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cfg(input int l, input int p);
        bus.SC_LANESCHED_cfgWrite_In  = 1'b1;
        bus.SC_LANESCHED_cfgLane_In   = 2'(l);
        bus.SC_LANESCHED_cfgPeriod_In = 8'(p);
        cyc();
        bus.SC_LANESCHED_cfgWrite_In  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!bus.SC_LANESCHED_shiftValid_Out && n < budget) begin cyc(); n++; end
        if (n >= budget) chk({tag, "_timeout"}, 32'(n), 32'(budget - 1));
    endtask

    initial begin
        int last, gap_cnt, quiet, order_idx;
        int order [5];
        bus.SC_LANESCHED_run_In        = 1'b0;
        bus.SC_LANESCHED_cfgWrite_In   = 1'b0;
        bus.SC_LANESCHED_cfgLane_In    = 2'd0;
        bus.SC_LANESCHED_cfgPeriod_In  = 8'd0;
        bus.SC_LANESCHED_shiftReady_In = 1'b0;
        do_reset();
        chk("rst_valid", 32'(bus.SC_LANESCHED_shiftValid_Out), 32'd0);
        chk("rst_sel",   32'(bus.SC_LANESCHED_shiftselection_Out), 32'd3);
        chk("rst_busy",  32'(bus.SC_LANESCHED_busy_Out), 32'd0);

        // Lane 0, period 2: one pulse every 8 cycles.
        cfg(0, 2);
        bus.SC_LANESCHED_run_In = 1'b1;
        bus.SC_LANESCHED_shiftReady_In = 1'b1;
        last = -1; gap_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (bus.SC_LANESCHED_shiftValid_Out) begin
                chk("r031_lane", 32'(bus.SC_LANESCHED_shiftLane_Out), 32'd0);
                chk("r031_sel",  32'(bus.SC_LANESCHED_shiftselection_Out), 32'd2);
                if (last >= 0) begin chk("r031_gap", 32'(c - last), 32'd8); gap_cnt++; end
                last = c;
            end
        end
        chk("r031_pulses", 32'(gap_cnt >= 3), 32'd1);

        // All lanes period 1: issue order 0,1,2,3,0 two cycles apart.
        bus.SC_LANESCHED_run_In = 1'b0;
        do_reset();
        for (int l = 0; l < 4; l++) cfg(l, 1);
        bus.SC_LANESCHED_run_In = 1'b1;
        order_idx = 0; last = -1;
        for (int c = 0; c < 30 && order_idx < 5; c++) begin
            cyc();
            if (bus.SC_LANESCHED_shiftValid_Out) begin
                order[order_idx] = int'(bus.SC_LANESCHED_shiftLane_Out);
                if (last >= 0 && order_idx < 4) chk("r032_gap", 32'(c - last), 32'd2);
                last = c;
                order_idx++;
            end
        end
        chk("r032_count", 32'(order_idx), 32'd5);
        for (int k = 0; k < 5; k++) chk("r032_order", 32'(order[k]), 32'(k % 4));

        // Lane 1 held unaccepted: stable command, then an overrun.
        bus.SC_LANESCHED_run_In = 1'b0;
        do_reset();
        bus.SC_LANESCHED_shiftReady_In = 1'b0;
        cfg(1, 1);
        bus.SC_LANESCHED_run_In = 1'b1;
        for (int c = 0; c < 12; c++) cyc();
        chk("r033_valid", 32'(bus.SC_LANESCHED_shiftValid_Out), 32'd1);
        chk("r033_lane",  32'(bus.SC_LANESCHED_shiftLane_Out), 32'd1);
        chk("r033_sel",   32'(bus.SC_LANESCHED_shiftselection_Out), 32'd1);
`ifdef SC_LANESCHED_OVERRUN_EN
        chk("r033_ovr", 32'(bus.SC_LANESCHED_overrun_Out), 32'b0010);
`else
        chk("r033_ovr", 32'(bus.SC_LANESCHED_overrun_Out), 32'b0000);
`endif

        // run falls during ISSUE: valid held until ready, then idle.
        bus.SC_LANESCHED_run_In = 1'b0;
        for (int c = 0; c < 3; c++) cyc();
        chk("r034_hold", 32'(bus.SC_LANESCHED_shiftValid_Out), 32'd1);
        bus.SC_LANESCHED_shiftReady_In = 1'b1;
        cyc();
        chk("r034_busy", 32'(bus.SC_LANESCHED_busy_Out), 32'd0);
        for (int c = 0; c < 6; c++) cyc();

        // Reset during ISSUE, colliding with a write: nothing issues afterwards.
        bus.SC_LANESCHED_shiftReady_In = 1'b0;
        bus.SC_LANESCHED_run_In = 1'b1;
        wait_valid("r036", 20);
        rst = 1'b1;
        bus.SC_LANESCHED_cfgWrite_In = 1'b1;
        bus.SC_LANESCHED_cfgLane_In = 2'd2;
        bus.SC_LANESCHED_cfgPeriod_In = 8'd1;
        cyc();
        rst = 1'b0;
        bus.SC_LANESCHED_cfgWrite_In = 1'b0;
        chk("r036_valid", 32'(bus.SC_LANESCHED_shiftValid_Out), 32'd0);
        chk("r036_sel",   32'(bus.SC_LANESCHED_shiftselection_Out), 32'd3);
        chk("r036_ovr",   32'(bus.SC_LANESCHED_overrun_Out), 32'd0);
        bus.SC_LANESCHED_shiftReady_In = 1'b1;
        quiet = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (bus.SC_LANESCHED_shiftValid_Out) quiet++;
        end
        chk("r036_quiet", 32'(quiet), 32'd0);

        // Random traffic with varying ready pressure.
        for (int blk = 0; blk < 15; blk++) begin
            int ready_pct = $urandom_range(10, 100);
            for (int c = 0; c < 200; c++) begin
                rst = ($urandom_range(0, 399) == 0);
                if ($urandom_range(0, 49) == 0) bus.SC_LANESCHED_run_In = ~bus.SC_LANESCHED_run_In;
                bus.SC_LANESCHED_shiftReady_In = ($urandom_range(1, 100) <= ready_pct);
                bus.SC_LANESCHED_cfgWrite_In   = ($urandom_range(0, 24) == 0);
                bus.SC_LANESCHED_cfgLane_In    = 2'($urandom_range(0, 3));
                bus.SC_LANESCHED_cfgPeriod_In  = 8'($urandom_range(0, 5));
                cyc();
            end
        end
        rst = 1'b0;
        bus.SC_LANESCHED_cfgWrite_In = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
